// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES encryptor, one round per cycle; AES_ENC_ITER_PERF_CNT_EN adds blk_cnt.
// Latency NR cycles accept->out_valid; one block in flight, in_ready only when idle, result held until out_ready.
module aes_enc_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    output logic [3:0]   key_addr,
    input  logic [127:0] rkey,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout
`ifdef AES_ENC_ITER_PERF_CNT_EN
    ,
    output logic [31:0]  blk_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_t;

    localparam logic [3:0] NR_L = 4'(NR);

    // FIPS-197 S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte (row r, column c) lives at index r + 4c, MSB first; row r rotates left by r.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    fsm_t         state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] ss_blk;

    assign ss_blk = sub_shift(blk_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        blk_d     = blk_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    blk_d   = din ^ rkey;
                    cnt_d   = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (cnt_q == NR_L) begin
                    blk_d   = ss_blk ^ rkey;
                    state_d = DONE;
                end else begin
                    blk_d = mix_columns(ss_blk) ^ rkey;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
        end
    end

    // Counter doubles as the round-key index: 0 when idle, holds NR while the result waits.
    assign key_addr = cnt_q;
    assign dout     = blk_q;

`ifdef AES_ENC_ITER_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt <= 32'd0;
        end else if (state_q == DONE && out_ready) begin
            blk_cnt <= blk_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_enc_iter.sv
// Bench for aes_enc_iter: NR=10/12/14 instances against a byte-level AES model with generated S-box.
module tb_aes_enc_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst[3], in_valid[3], out_ready[3];
    logic         in_ready[3], out_valid[3];
    logic [127:0] din[3], dout[3], rkey[3];
    logic [3:0]   key_addr[3];
`ifdef AES_ENC_ITER_PERF_CNT_EN
    logic [31:0]  blk_cnt[3];
`endif

    logic [127:0] rk[3][16];
    logic [7:0]   sb[256];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic         b2b[3] = '{1'b0, 1'b0, 1'b0};
    logic         m_init[3] = '{1'b0, 1'b0, 1'b0};
    logic         m_busy[3] = '{1'b0, 1'b0, 1'b0};
    logic         m_after_rst[3] = '{1'b0, 1'b0, 1'b0};
    int           m_k[3] = '{0, 0, 0};
    int           m_dcyc[3] = '{0, 0, 0};
    int           acc_cnt[3] = '{0, 0, 0};
    int           m_prev_acc[3] = '{-1, -1, -1};
    logic [127:0] m_exp[3];
    logic [3:0]   m_last_ka[3];

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        aes_enc_iter #(.NR(10 + 2*g)) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .din      (din[g]),
            .key_addr (key_addr[g]),
            .rkey     (rkey[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .dout     (dout[g])
`ifdef AES_ENC_ITER_PERF_CNT_EN
            ,
            .blk_cnt  (blk_cnt[g])
`endif
        );
        assign rkey[g] = rk[g][key_addr[g]];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_to(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Straightforward FIPS-197 cipher on a 4x4 byte matrix.
    function automatic logic [127:0] aes_model(input logic [127:0] pt, input int g);
        logic [7:0]   s[4][4];
        logic [7:0]   t[4][4];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] v;
        int nr;
        nr = 10 + 2*g;
        v = pt ^ rk[g][0];
        for (int r = 1; r <= nr; r++) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) s[w][c] = v[127 - 8*(w + 4*c) -: 8];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[w][c] = sb[s[w][(c + w) % 4]];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
                    t[0][c] = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                    t[1][c] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                    t[2][c] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                    t[3][c] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) v[127 - 8*(w + 4*c) -: 8] = t[w][c];
            v = v ^ rk[g][r];
        end
        return v;
    endfunction

    task automatic expand(input int g, input logic [255:0] key);
        logic [31:0] w[60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nr;
        nr = 10 + 2*g;
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk[g][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    // Compare process: timing expectations are counted in edges since the accept edge.
    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < 3; g++) begin
            int nr;
            string p;
            nr = 10 + 2*g;
            p = $sformatf("nr%0d", nr);
            if (m_init[g]) begin
                if (!m_busy[g]) begin
                    chk({p, " idle in_ready"}, 128'(in_ready[g]), 128'(1));
                    chk({p, " idle out_valid"}, 128'(out_valid[g]), 128'(0));
                    chk({p, " idle key_addr"}, 128'(key_addr[g]), 128'(0));
                    if (m_after_rst[g]) chk({p, " reset dout"}, dout[g], 128'(0));
                end else if (m_k[g] < nr) begin
                    chk({p, " round in_ready"}, 128'(in_ready[g]), 128'(0));
                    chk({p, " round out_valid"}, 128'(out_valid[g]), 128'(0));
                    chk({p, " round key_addr"}, 128'(key_addr[g]), 128'(m_k[g] + 1));
                end else begin
                    chk({p, " done in_ready"}, 128'(in_ready[g]), 128'(0));
                    chk({p, " done out_valid"}, 128'(out_valid[g]), 128'(1));
                    chk({p, " done dout"}, dout[g], m_exp[g]);
                    chk({p, " done key_addr range"}, 128'(int'(key_addr[g]) <= nr), 128'(1));
                    if (m_dcyc[g] > 0)
                        chk({p, " done key_addr stable"}, 128'(key_addr[g]), 128'(m_last_ka[g]));
                end
                m_last_ka[g] = key_addr[g];
            end
            if (rst[g] === 1'b1) begin
                m_init[g]      = 1'b1;
                m_busy[g]      = 1'b0;
                m_after_rst[g] = 1'b1;
            end else if (m_init[g]) begin
                if (!m_busy[g]) begin
                    if (in_valid[g]) begin
                        if (b2b[g] && m_prev_acc[g] >= 0)
                            chk({p, " accept spacing"}, 128'(cyc - m_prev_acc[g]), 128'(nr + 2));
                        m_prev_acc[g]  = cyc;
                        m_busy[g]      = 1'b1;
                        m_k[g]         = 0;
                        m_dcyc[g]      = 0;
                        m_after_rst[g] = 1'b0;
                        m_exp[g]       = aes_model(din[g], g);
                        acc_cnt[g]++;
                    end
                end else if (m_k[g] < nr) begin
                    m_k[g]++;
                end else if (out_ready[g]) begin
                    m_busy[g] = 1'b0;
                end else begin
                    m_dcyc[g]++;
                end
            end
            if (!b2b[g]) m_prev_acc[g] = -1;
        end
    end

    task automatic send(input int g, input logic [127:0] pt);
        din[g] = pt;
        in_valid[g] = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready[g]) begin
                @(posedge clk);
                #1;
                in_valid[g] = 1'b0;
                return;
            end
        end
        in_valid[g] = 1'b0;
        fail_to("send");
    endtask

    task automatic wait_valid(input int g, output int lat);
        lat = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (out_valid[g]) return;
            lat++;
        end
        lat = -1;
        fail_to("wait_valid");
    endtask

    task automatic run_kat(input int g, input logic [127:0] pt, input logic [127:0] want);
        int lat;
        send(g, pt);
        wait_valid(g, lat);
        chk($sformatf("nr%0d latency", 10 + 2*g), 128'(lat), 128'(10 + 2*g));
        chk($sformatf("nr%0d ciphertext", 10 + 2*g), dout[g], want);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int g);
        in_valid[g] = 1'b0;
        out_ready[g] = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (!m_busy[g]) return;
        end
        fail_to("drain");
    endtask

    task automatic b2b_run(input int g, input int n);
        int target;
        target = acc_cnt[g] + n;
        b2b[g] = 1'b1;
        out_ready[g] = 1'b1;
        in_valid[g] = 1'b1;
        for (int i = 0; i < n*(12 + 2*g) + 40; i++) begin
            @(posedge clk);
            #1;
            din[g] = rand128();
            if (acc_cnt[g] >= target) break;
        end
        in_valid[g] = 1'b0;
        if (acc_cnt[g] < target) fail_to("b2b accepts");
        drain(g);
        b2b[g] = 1'b0;
    endtask

    localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

    initial begin
        logic [127:0] kat[3];
        logic [7:0] inv;
        int lat;
        kat[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        kat[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        kat[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
        for (int g = 0; g < 3; g++) begin
            rst[g] = 1'b1; in_valid[g] = 1'b0; out_ready[g] = 1'b1; din[g] = '0;
        end
        // S-box from the multiplicative inverse plus affine map.
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int g = 0; g < 3; g++) expand(g, KEY);
        chk("model sbox[00]", 128'(sb[8'h00]), 128'(8'h63));
        chk("model sbox[53]", 128'(sb[8'h53]), 128'(8'hed));
        chk("model nr10 rk10", rk[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        for (int g = 0; g < 3; g++) chk($sformatf("model kat%0d", g), aes_model(PT, g), kat[g]);

        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) rst[g] = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("post-reset in_ready", 128'(in_ready[g]), 128'(1));
            chk("post-reset dout", dout[g], 128'(0));
`ifdef AES_ENC_ITER_PERF_CNT_EN
            chk("post-reset blk_cnt", 128'(blk_cnt[g]), 128'(0));
`endif
        end
        @(posedge clk);
        #1;

        for (int g = 0; g < 3; g++) run_kat(g, PT, kat[g]);

        // Consumer stall with ignored in_valid pulses.
        out_ready[0] = 1'b0;
        send(0, rand128());
        wait_valid(0, lat);
        repeat (20) begin
            @(posedge clk);
            #1;
            in_valid[0] = 1'($urandom_range(0, 1));
            din[0] = rand128();
        end
        @(negedge clk);
        chk("stall in_ready", 128'(in_ready[0]), 128'(0));
        chk("stall out_valid", 128'(out_valid[0]), 128'(1));
        @(posedge clk);
        #1;
        drain(0);

        // Reset mid-round, held across an idle cycle with in_valid high.
        send(0, rand128());
        repeat (4) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        in_valid[0] = 1'b1;
        din[0] = rand128();
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("abort out_valid", 128'(out_valid[0]), 128'(0));
        chk("abort in_ready", 128'(in_ready[0]), 128'(1));
        chk("abort key_addr", 128'(key_addr[0]), 128'(0));
        @(posedge clk);
        #1;
        run_kat(0, PT, kat[0]);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            in_valid[0] = 1'($urandom_range(0, 1));
            out_ready[0] = ($urandom_range(0, 3) != 0);
            din[0] = rand128();
        end
        drain(0);

        b2b_run(0, 100);
        b2b_run(1, 20);
        b2b_run(2, 20);

`ifdef AES_ENC_ITER_PERF_CNT_EN
        force gen_dut[0].u_dut.blk_cnt = 32'hFFFFFFFE;
        @(posedge clk);
        #1;
        release gen_dut[0].u_dut.blk_cnt;
        run_kat(0, PT, kat[0]);
        chk("blk_cnt to max", 128'(blk_cnt[0]), 128'(32'hFFFFFFFF));
        run_kat(0, PT, kat[0]);
        chk("blk_cnt wrap", 128'(blk_cnt[0]), 128'(32'h00000000));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
